// File: rtl/i2c_slave_if.sv
// Parallel-side handshake of the I2C responder: write bytes out,
// read bytes in, plus status pulses.
interface i2c_slave_if;
   logic       rx_ack_en;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic       busy;
   logic       stop;

   modport master (
      output rx_ack_en, tx_data,
      input  rx_data, rx_valid, tx_req, busy, stop
   );

   modport slave (
      input  rx_ack_en, tx_data,
      output rx_data, rx_valid, tx_req, busy, stop
   );
endinterface

// File: rtl/i2c_slave.sv
// I2C responder: synchronized SCL/SDA, START/STOP detect, 7-bit address match.
// Define I2C_SLAVE_GLITCH_FILTER_EN for a 3-sample agreement filter on both lines.
module i2c_slave #(
   parameter logic [6:0] ADDR = 7'h42
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SCL,
   inout  tri          SDA,
   i2c_slave_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_AACK, S_RX, S_RACK, S_TX, S_MACK, S_IGNORE
   } state_e;

   logic [1:0] scl_s_q, scl_s_d, sda_s_q, sda_s_d;
   logic       scl_lvl_q, scl_lvl_d, sda_lvl_q, sda_lvl_d;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] scl_t_q, scl_t_d, sda_t_q, sda_t_d;
`endif

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [6:0] sh_q, sh_d;
   logic [6:0] tx_sh_q, tx_sh_d;
   logic       ph_q, ph_d;
   logic       rw_q, rw_d;
   logic       ack_en_q, ack_en_d;
   logic       oe_q, oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;
   logic       busy_q, busy_d;
   logic       stop_q, stop_d;

   logic       scl_r, scl_f, sda_r, sda_f;
   logic       start_ev, stop_ev;
   logic [7:0] byte_in;

   always_comb begin
      scl_s_d = {scl_s_q[0], SCL};
      sda_s_d = {sda_s_q[0], SDA};
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      // a level only moves once three consecutive samples agree
      scl_t_d   = {scl_t_q[0], scl_s_q[1]};
      sda_t_d   = {sda_t_q[0], sda_s_q[1]};
      scl_lvl_d = scl_lvl_q;
      sda_lvl_d = sda_lvl_q;
      if (scl_s_q[1] == scl_t_q[0] && scl_s_q[1] == scl_t_q[1])
         scl_lvl_d = scl_s_q[1];
      if (sda_s_q[1] == sda_t_q[0] && sda_s_q[1] == sda_t_q[1])
         sda_lvl_d = sda_s_q[1];
`else
      scl_lvl_d = scl_s_q[1];
      sda_lvl_d = sda_s_q[1];
`endif
   end

   assign scl_r    = scl_lvl_d & ~scl_lvl_q;
   assign scl_f    = ~scl_lvl_d & scl_lvl_q;
   assign sda_r    = sda_lvl_d & ~sda_lvl_q;
   assign sda_f    = ~sda_lvl_d & sda_lvl_q;
   assign start_ev = sda_f & scl_lvl_d;
   assign stop_ev  = sda_r & scl_lvl_d;
   assign byte_in  = {sh_q, sda_lvl_d};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      tx_sh_d    = tx_sh_q;
      ph_d       = ph_q;
      rw_d       = rw_q;
      ack_en_d   = ack_en_q;
      oe_d       = oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      busy_d     = busy_q;
      stop_d     = 1'b0;

      if (start_ev) begin
         state_d = S_ADDR;
         cnt_d   = 3'd0;
         sh_d    = 7'd0;
         ph_d    = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (stop_ev) begin
         state_d = S_IDLE;
         cnt_d   = 3'd0;
         ph_d    = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
         stop_d  = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE, S_IGNORE: begin
            end
            S_ADDR: begin
               if (scl_r) begin
                  sh_d  = byte_in[6:0];
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     rw_d = byte_in[0];
                     if (byte_in[7:1] == ADDR && byte_in[7:1] != 7'd0) begin
                        state_d = S_AACK;
                        busy_d  = 1'b1;
                     end else begin
                        state_d = S_IGNORE;
                     end
                  end
               end
            end
            S_AACK: begin
               // ph_q marks that the ACK bit itself is on the wire
               if (scl_f && !ph_q) begin
                  ph_d = 1'b1;
                  oe_d = 1'b1;
               end else if (scl_f) begin
                  ph_d  = 1'b0;
                  cnt_d = 3'd0;
                  if (rw_q) begin
                     tx_sh_d = bus.tx_data[6:0];
                     oe_d    = ~bus.tx_data[7];
                     state_d = S_TX;
                  end else begin
                     oe_d    = 1'b0;
                     state_d = S_RX;
                  end
               end else if (scl_r && ph_q) begin
                  tx_req_d = rw_q;
               end
            end
            S_RX: begin
               if (scl_r) begin
                  sh_d  = byte_in[6:0];
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     rx_data_d  = byte_in;
                     rx_valid_d = 1'b1;
                     ack_en_d   = bus.rx_ack_en;
                     ph_d       = 1'b0;
                     state_d    = S_RACK;
                  end
               end
            end
            S_RACK: begin
               if (scl_f && !ph_q) begin
                  ph_d = 1'b1;
                  oe_d = ack_en_q;
               end else if (scl_f) begin
                  ph_d    = 1'b0;
                  oe_d    = 1'b0;
                  state_d = S_RX;
               end
            end
            S_TX: begin
               if (scl_f) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     oe_d    = 1'b0;
                     ph_d    = 1'b0;
                     state_d = S_MACK;
                  end else begin
                     tx_sh_d = {tx_sh_q[5:0], 1'b0};
                     oe_d    = ~tx_sh_q[6];
                  end
               end
            end
            S_MACK: begin
               if (scl_r && !ph_q) begin
                  if (!sda_lvl_d) begin
                     ph_d     = 1'b1;
                     tx_req_d = 1'b1;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = S_IGNORE;
                  end
               end else if (scl_f && ph_q) begin
                  tx_sh_d = bus.tx_data[6:0];
                  oe_d    = ~bus.tx_data[7];
                  ph_d    = 1'b0;
                  cnt_d   = 3'd0;
                  state_d = S_TX;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_s_q    <= 2'b11;
         sda_s_q    <= 2'b11;
         scl_lvl_q  <= 1'b1;
         sda_lvl_q  <= 1'b1;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
         scl_t_q    <= 2'b11;
         sda_t_q    <= 2'b11;
`endif
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         sh_q       <= 7'd0;
         tx_sh_q    <= 7'd0;
         ph_q       <= 1'b0;
         rw_q       <= 1'b0;
         ack_en_q   <= 1'b0;
         oe_q       <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_s_q    <= scl_s_d;
         sda_s_q    <= sda_s_d;
         scl_lvl_q  <= scl_lvl_d;
         sda_lvl_q  <= sda_lvl_d;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
         scl_t_q    <= scl_t_d;
         sda_t_q    <= sda_t_d;
`endif
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         tx_sh_q    <= tx_sh_d;
         ph_q       <= ph_d;
         rw_q       <= rw_d;
         ack_en_q   <= ack_en_d;
         oe_q       <= oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= busy_d;
         stop_q     <= stop_d;
      end
   end

   assign SDA          = oe_q ? 1'b0 : 1'bz;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.tx_req   = tx_req_q;
   assign bus.busy     = busy_q;
   assign bus.stop     = stop_q;

endmodule
